mem_lsu_stage: RTL and testbench

//  MEM pipeline stage with load/store engine: sits between EX/MEM and MEM/WB latches.
//  Non-memory instructions pass wd/wreg/wdata through combinationally, zero latency.

---
 rtl/mem_lsu_stage.sv | 154 +++++++++++++++
 tb/tb_mem_lsu_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_stage.sv
// MEM stage with a byte-serial load/store engine on an 8-bit RAM port.
// ALU results pass straight through; memory ops stall until the access ends.
module mem_lsu_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic                  mem_en_i,
  input  logic                  mem_we_i,
  input  logic [2:0]            mem_op_i,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]       mem_sdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  stall_req_o,
  output logic                  mem_err_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [MEM_ADDR_W-1:0] ram_addr_o,
  output logic [7:0]            ram_wdata_o,
  input  logic [7:0]            ram_rdata_i,
  input  logic                  ram_ack_i
);

  localparam int NB = XLEN / 8;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, beats;
  logic [2:0]            op_q;
  logic                  we_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       sdata_q, buf_q, ext;
  logic [7:0]            wbyte;
  logic                  legal, last;

  assign legal = mem_op_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  assign last  = (cnt == beats - CW'(1));

  always_comb begin
    beats = CW'(NB);
    unique case (1'b1)
      (op_q[1:0] == 2'd0): beats = CW'(1);
      (op_q[1:0] == 2'd1): beats = CW'(2);
      default:             beats = CW'(NB);
    endcase
  end

  always_comb begin
    wbyte = '0;
    for (int i = 0; i < NB; i++)
      if (cnt == CW'(i)) wbyte = sdata_q[i*8 +: 8];
  end

  always_comb begin
    ext = buf_q;
    unique case (1'b1)
      (op_q == 3'd0): ext = {{(XLEN-8){buf_q[7]}}, buf_q[7:0]};
      (op_q == 3'd1): ext = {{(XLEN-16){buf_q[15]}}, buf_q[15:0]};
      (op_q == 3'd4): ext = {{(XLEN-8){1'b0}}, buf_q[7:0]};
      (op_q == 3'd5): ext = {{(XLEN-16){1'b0}}, buf_q[15:0]};
      default:        ext = buf_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && mem_en_i && legal) begin
        cnt     <= '0;
        op_q    <= mem_op_i;
        we_q    <= mem_we_i;
        addr_q  <= mem_addr_i;
        sdata_q <= mem_sdata_i;
        buf_q   <= '0;
      end else if (state == XFER && ram_ack_i) begin
        cnt <= cnt + CW'(1);
        if (!we_q)
          for (int i = 0; i < NB; i++)
            if (cnt == CW'(i)) buf_q[i*8 +: 8] <= ram_rdata_i;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stall_req_o = 1'b0;
    mem_err_o   = 1'b0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    unique case (state)
      IDLE: begin
        if (mem_en_i) begin
          wreg_o = 1'b0;
          if (legal) begin
            stall_req_o = 1'b1;
            state_nx    = XFER;
          end else begin
            mem_err_o = 1'b1;
          end
        end
      end
      XFER: begin
        stall_req_o = 1'b1;
        wreg_o      = 1'b0;
        ram_req_o   = 1'b1;
        ram_we_o    = we_q;
        ram_addr_o  = addr_q + MEM_ADDR_W'(cnt);
        ram_wdata_o = wbyte;
        if (ram_ack_i && last) state_nx = DONE;
      end
      DONE: begin
        if (!we_q) wdata_o = ext;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // outputs collapse to zero the moment reset asserts, even mid-access
    if (!rst) begin
      state_nx    = IDLE;
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      stall_req_o = 1'b0;
      mem_err_o   = 1'b0;
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: vector tables, hand sequences and random
// loads/stores checked against a byte-array memory model.
module tb_mem_lsu_stage;

  logic        clk = 0;
  logic        rst = 0;
  logic [4:0]  wd_i = 0;
  logic        wreg_i = 0;
  logic [31:0] wdata_i = 0;
  logic        mem_en_i = 0;
  logic        mem_we_i = 0;
  logic [2:0]  mem_op_i = 0;
  logic [31:0] mem_addr_i = 0;
  logic [31:0] mem_sdata_i = 0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, mem_err_o;
  logic        ram_req_o, ram_we_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata_i = 0;
  logic        ram_ack_i = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_mode = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } beat_t;

  beat_t    beat_q[$];
  bit [7:0] mem [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];

  mem_lsu_stage dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_en_i(mem_en_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req_o(stall_req_o), .mem_err_o(mem_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] rd(bit [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic bit [7:0] rref(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] op, logic [31:0] a);
    logic [31:0] w;
    w = {rref(a + 3), rref(a + 2), rref(a + 1), rref(a)};
    case (op)
      3'd0:    return 32'($signed(w[7:0]));
      3'd1:    return 32'($signed(w[15:0]));
      3'd4:    return 32'(w[7:0]);
      3'd5:    return 32'(w[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic int nbeats(logic [2:0] op);
    return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // RAM responder: beat completes at the edge where req and ack are both high
  always @(posedge clk) begin
    if (ram_req_o && ram_ack_i) begin
      beat_q.push_back('{ram_addr_o, ram_we_o, ram_wdata_o});
      if (ram_we_o) mem[ram_addr_o] = ram_wdata_o;
    end
    #1;
    case (ack_mode)
      0:       ram_ack_i = 1'b1;
      1:       ram_ack_i = ~ram_ack_i;
      default: ram_ack_i = 1'($urandom % 2);
    endcase
    ram_rdata_i = rd(ram_addr_o);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_mem(input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] exp_wdata,
                        input bit scramble);
    int n;
    int cyc;
    bit tmo;
    n = nbeats(op);
    tmo = 0;
    @(posedge clk); #2;
    beat_q.delete();
    mem_en_i = 1; mem_we_i = we; mem_op_i = op;
    mem_addr_i = addr; mem_sdata_i = sdata;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    #1;
    chk("start_stall", stall_req_o, 1);
    chk("start_wreg", wreg_o, 0);
    chk("start_req", ram_req_o, 0);
    cyc = 0;
    forever begin
      @(posedge clk); #3;
      cyc++;
      if (!stall_req_o) break;
      if (cyc > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL xfer_timeout: got stall after %0d cycles expected done", cyc);
        tmo = 1;
        break;
      end
      chk("xfer_req", ram_req_o, 1);
      chk("xfer_we", ram_we_o, we);
      chk("xfer_addr", ram_addr_o, addr + beat_q.size());
      if (we) chk("xfer_wbyte", ram_wdata_o, 8'(sdata >> (8 * beat_q.size())));
      if (scramble) begin
        mem_addr_i = $urandom;
        mem_sdata_i = $urandom;
      end
    end
    if (!tmo) begin
      chk("done_wd", wd_o, wd);
      chk("done_wreg", wreg_o, wreg);
      chk("done_wdata", wdata_o, exp_wdata);
      chk("done_req", ram_req_o, 0);
      chk("done_err", mem_err_o, 0);
    end
    mem_en_i = 0;
    chk("beat_count", beat_q.size(), n);
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      chk("beat_addr", beat_q[i].addr, addr + i);
      chk("beat_we", beat_q[i].we, we);
      if (we) chk("beat_data", beat_q[i].data, 8'(sdata >> (8 * i)));
    end
    if (we)
      for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(sdata >> (8 * i));
  endtask

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [4:0]  exp_wd;
    logic        exp_wreg;
    logic [31:0] exp_wdata;
  } pt_vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          ackm;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] exp_wdata;
  } mem_vec_t;

  pt_vec_t  pt[4];
  mem_vec_t mv[8];

  task automatic poke(logic [31:0] a, logic [7:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  initial begin
    pt[0] = '{5'd5,  1'b1, 32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234};
    pt[1] = '{5'd0,  1'b0, 32'h0000_0000, 5'd0,  1'b0, 32'h0000_0000};
    pt[2] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF};
    pt[3] = '{5'd17, 1'b0, 32'hDEAD_BEEF, 5'd17, 1'b0, 32'hDEAD_BEEF};

    mv[0] = '{1'b0, 3'd0, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h0, 32'hFFFF_FF80};
    mv[1] = '{1'b0, 3'd4, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h0, 32'h0000_0080};
    mv[2] = '{1'b0, 3'd2, 32'h0000_0203, 32'h0, 1, 1'b1, 32'h0, 32'h4433_2211};
    mv[3] = '{1'b0, 3'd1, 32'h0000_0300, 32'h0, 0, 1'b1, 32'h0, 32'hFFFF_8001};
    mv[4] = '{1'b0, 3'd5, 32'h0000_0300, 32'h0, 1, 1'b1, 32'h0, 32'h0000_8001};
    mv[5] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 1'b0, 32'h0000_0AAA, 32'h0000_0AAA};
    mv[6] = '{1'b1, 3'd2, 32'h0000_03FE, 32'h1234_5678, 2, 1'b0, 32'h0000_0BBB, 32'h0000_0BBB};
    mv[7] = '{1'b0, 3'd2, 32'h0000_03FE, 32'h0, 2, 1'b1, 32'h0, 32'h1234_5678};

    poke(32'h100, 8'h80);
    poke(32'h203, 8'h11); poke(32'h204, 8'h22);
    poke(32'h205, 8'h33); poke(32'h206, 8'h44);
    poke(32'h300, 8'h01); poke(32'h301, 8'h80);

    // reset state with live-looking inputs
    wd_i = 5'd7; wreg_i = 1; wdata_i = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_stall", stall_req_o, 0);
    chk("rst_req", ram_req_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    rst = 1;

    foreach (pt[i]) begin
      @(posedge clk); #2;
      mem_en_i = 0; mem_op_i = 3'd3; mem_addr_i = $urandom;
      wd_i = pt[i].wd; wreg_i = pt[i].wreg; wdata_i = pt[i].wdata;
      #1;
      chk("pt_wd", wd_o, pt[i].exp_wd);
      chk("pt_wreg", wreg_o, pt[i].exp_wreg);
      chk("pt_wdata", wdata_o, pt[i].exp_wdata);
      chk("pt_stall", stall_req_o, 0);
      chk("pt_err", mem_err_o, 0);
      chk("pt_req", ram_req_o, 0);
    end

    foreach (mv[i]) begin
      ack_mode = mv[i].ackm;
      do_mem(mv[i].we, mv[i].op, mv[i].addr, mv[i].sdata, 5'(i + 1),
             mv[i].wreg, mv[i].wdata, mv[i].exp_wdata, 0);
    end
    chk("sh_byte_lo", rd(32'hFFFF_FFFF), 8'hEF);
    chk("sh_byte_hi", rd(32'h0000_0000), 8'hBE);

    // illegal op codes: one-cycle error, no RAM traffic
    ack_mode = 0;
    foreach (mv[i]) begin
      logic [2:0] bad;
      if (i > 2) break;
      bad = (i == 0) ? 3'd3 : (i == 1) ? 3'd6 : 3'd7;
      @(posedge clk); #2;
      beat_q.delete();
      mem_en_i = 1; mem_we_i = 0; mem_op_i = bad; wreg_i = 1;
      #1;
      chk("ill_err", mem_err_o, 1);
      chk("ill_stall", stall_req_o, 0);
      chk("ill_wreg", wreg_o, 0);
      chk("ill_req", ram_req_o, 0);
      mem_en_i = 0;
      @(posedge clk); #3;
      chk("ill_err_gone", mem_err_o, 0);
      chk("ill_req_after", ram_req_o, 0);
      chk("ill_beats", beat_q.size(), 0);
    end

    // reset during a word store, after its first beat
    poke(32'h41, 8'h00);
    @(posedge clk); #2;
    mem_en_i = 1; mem_we_i = 1; mem_op_i = 3'd2;
    mem_addr_i = 32'h40; mem_sdata_i = 32'hA1B2_C3D4;
    wd_i = 5'd9; wreg_i = 1; wdata_i = 32'h55;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("mrst_req", ram_req_o, 0);
    chk("mrst_stall", stall_req_o, 0);
    chk("mrst_wd", wd_o, 0);
    chk("mrst_wreg", wreg_o, 0);
    chk("mrst_wdata", wdata_o, 0);
    chk("mrst_we", ram_we_o, 0);
    chk("mrst_addr", ram_addr_o, 0);
    chk("mrst_wbyte", ram_wdata_o, 0);
    @(posedge clk); #3;
    chk("mrst_b0_kept", rd(32'h40), 8'hD4);
    chk("mrst_b1_none", rd(32'h41), 8'h00);
    ref_mem[32'h40] = 8'hD4;
    mem_en_i = 0; wd_i = 5'd3; wreg_i = 1; wdata_i = 32'h77;
    rst = 1;
    @(posedge clk); #3;
    chk("mrst_idle_wd", wd_o, 3);
    chk("mrst_idle_wreg", wreg_o, 1);
    chk("mrst_idle_stall", stall_req_o, 0);
    do_mem(0, 3'd2, 32'h40, 0, 5'd4, 1, 0, 32'h0000_00D4, 0);

    // random back-to-back traffic with random ack and moving inputs
    ack_mode = 2;
    for (int k = 0; k < 40; k++) begin
      logic        we;
      logic [2:0]  op;
      logic [31:0] a, sd, exp;
      we = 1'($urandom % 2);
      if (we) op = 3'($urandom % 3);
      else begin
        case ($urandom % 5)
          0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd2;
          3: op = 3'd4; default: op = 3'd5;
        endcase
      end
      a = ($urandom % 8 == 0) ? 32'hFFFF_FFFC + ($urandom % 4)
                              : 32'h1000 + ($urandom % 32);
      sd = $urandom;
      exp = we ? 32'h0000_0C00 + k : model_load(op, a);
      do_mem(we, op, a, sd, 5'($urandom), !we, 32'h0000_0C00 + k, exp, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
